// File: rtl/core_load_unit.sv
// core_load_unit
//
// Load path between the memory stage and the register-file writeback port.
// It takes one load request at a time and issues one aligned bus read, or two
// when the access crosses a bus word and splitting is enabled. It extracts,
// shifts and extends the addressed field, then emits a single-cycle writeback
// pulse.
//
// Ports
//   i_clk, i_reset_n            clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready   request handshake; ready only while idle
//   i_req_addr, i_req_funct3,   byte address, load type, destination register
//   i_req_rd
//   o_bus_req, o_bus_addr       registered read strobe and aligned address
//   i_bus_ack, i_bus_rdata      read data strobe and data
//   o_wb_valid, o_wb_rd,        one-cycle writeback pulse, destination, result,
//   o_wb_data, o_wb_fault       and fault flag (illegal type or misaligned)
module core_load_unit #(
  parameter int XLEN          = 32,
  parameter int AW            = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [2:0]      i_req_funct3,
  input  logic [4:0]      i_req_rd,
  output logic            o_bus_req,
  output logic [AW-1:0]   o_bus_addr,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_wb_fault
);

  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Shift the two-beat window down to the addressed byte, then keep the field
  // and extend it. funct3[2] selects zero extension.
  function automatic logic [XLEN-1:0] form_load(input logic [2*XLEN-1:0] window,
                                                input logic [OW-1:0]     off,
                                                input logic [2:0]        funct3);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            msb;
    shifted = XLEN'(window >> {off, 3'b000});
    case (funct3[1:0])
      2'b00:   begin mask = XLEN'(8'hFF);         msb = shifted[7];      end
      2'b01:   begin mask = XLEN'(16'hFFFF);      msb = shifted[15];     end
      2'b10:   begin mask = XLEN'(32'hFFFF_FFFF); msb = shifted[31];     end
      default: begin mask = {XLEN{1'b1}};         msb = shifted[XLEN-1]; end
    endcase
    msb = funct3[2] ? 1'b0 : msb;
    return (shifted & mask) | ({XLEN{msb}} & ~mask);
  endfunction

  state_t            state_r;
  logic [2:0]        funct3_r;
  logic [4:0]        rd_r;
  logic [OW-1:0]     off_r;
  logic              cross_r;
  logic [XLEN-1:0]   beat0_r;
  logic              bus_req_r;
  logic [AW-1:0]     bus_addr_r;
  logic              wb_valid_r;
  logic [4:0]        wb_rd_r;
  logic [XLEN-1:0]   wb_data_r;
  logic              wb_fault_r;

  logic [OW-1:0]     req_off_s;
  logic [3:0]        req_size_s;
  logic              req_cross_s;
  logic              req_illegal_s;
  logic [AW-1:0]     req_aligned_s;
  logic [2*XLEN-1:0] window_s;
  logic [XLEN-1:0]   wb_data_s;

  assign req_off_s     = i_req_addr[OW-1:0];
  assign req_size_s    = 4'd1 << i_req_funct3[1:0];
  assign req_cross_s   = (4'(req_off_s) + req_size_s) > 4'(BYTES);
  assign req_aligned_s = {i_req_addr[AW-1:OW], {OW{1'b0}}};

  // Request-type legality depends on the data width.
  always_comb begin
    req_illegal_s = 1'b0;
    if (XLEN == 32) begin
      req_illegal_s = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                      (i_req_funct3 == 3'b111);
    end else begin
      req_illegal_s = (i_req_funct3 == 3'b111);
    end
  end

  // Window seen on the final ack: the live bus data fills the beat being acked,
  // so the result can be registered in the same cycle as that ack.
  always_comb begin
    window_s = {2*XLEN{1'b0}};
    case (state_r)
      BEAT0:   window_s = {{XLEN{1'b0}}, i_bus_rdata};
      BEAT1:   window_s = {i_bus_rdata, beat0_r};
      default: window_s = {{XLEN{1'b0}}, beat0_r};
    endcase
  end

  assign wb_data_s = form_load(window_s, off_r, funct3_r);

  // Load FSM with registered bus and writeback outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= IDLE;
      funct3_r   <= 3'b000;
      rd_r       <= 5'd0;
      off_r      <= {OW{1'b0}};
      cross_r    <= 1'b0;
      beat0_r    <= {XLEN{1'b0}};
      bus_req_r  <= 1'b0;
      bus_addr_r <= {AW{1'b0}};
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= {XLEN{1'b0}};
      wb_fault_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            funct3_r <= i_req_funct3;
            rd_r     <= i_req_rd;
            off_r    <= req_off_s;
            cross_r  <= req_cross_s;
            if (req_illegal_s || (req_cross_s && !MISALIGNED_EN)) begin
              state_r    <= RESP;
              wb_valid_r <= 1'b1;
              wb_fault_r <= 1'b1;
              wb_data_r  <= {XLEN{1'b0}};
              wb_rd_r    <= i_req_rd;
            end else begin
              state_r    <= BEAT0;
              bus_req_r  <= 1'b1;
              bus_addr_r <= req_aligned_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BEAT0: begin
          if (i_bus_ack) begin
            beat0_r <= i_bus_rdata;
            if (cross_r) begin
              state_r    <= BEAT1;
              bus_addr_r <= bus_addr_r + AW'(BYTES);
            end else begin
              state_r    <= RESP;
              bus_req_r  <= 1'b0;
              wb_valid_r <= 1'b1;
              wb_fault_r <= 1'b0;
              wb_data_r  <= wb_data_s;
              wb_rd_r    <= rd_r;
            end
          end else begin
            state_r <= BEAT0;
          end
        end
        BEAT1: begin
          if (i_bus_ack) begin
            state_r    <= RESP;
            bus_req_r  <= 1'b0;
            wb_valid_r <= 1'b1;
            wb_fault_r <= 1'b0;
            wb_data_r  <= wb_data_s;
            wb_rd_r    <= rd_r;
          end else begin
            state_r <= BEAT1;
          end
        end
        RESP: begin
          wb_valid_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          bus_req_r  <= 1'b0;
          wb_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = (state_r == IDLE);
  assign o_bus_req   = bus_req_r;
  assign o_bus_addr  = bus_addr_r;
  assign o_wb_valid  = wb_valid_r;
  assign o_wb_rd     = wb_rd_r;
  assign o_wb_data   = wb_data_r;
  assign o_wb_fault  = wb_fault_r;

endmodule
